// File: rtl/spi_cs_sequencer.sv
// spi_cs_sequencer
// Sits between a host byte stream and an SPI byte master. Groups up to
// MAX_BYTES_PER_CS bytes under one active-low chip select. Enforces CS setup,
// hold and inactive times counted in i_Clk cycles. Returns each received byte
// to the host, tagged with its 0-based index within the transaction.
module spi_cs_sequencer #(
  parameter int MAX_BYTES_PER_CS = 2,
  parameter int CS_SETUP_CLKS    = 4,
  parameter int CS_HOLD_CLKS     = 4,
  parameter int CS_INACTIVE_CLKS = 8,
  parameter int CW               = $clog2(MAX_BYTES_PER_CS + 1)
) (
  input  logic          i_Clk,
  input  logic          i_Rst_L,
  // host side
  input  logic [CW-1:0] i_TX_Count,
  input  logic [7:0]    i_TX_Byte,
  input  logic          i_TX_DV,
  output logic          o_TX_Ready,
  output logic [CW-1:0] o_RX_Count,
  output logic          o_RX_DV,
  output logic [7:0]    o_RX_Byte,
  // SPI byte master side
  output logic [7:0]    o_M_TX_Byte,
  output logic          o_M_TX_DV,
  input  logic          i_M_TX_Ready,
  input  logic          i_M_RX_DV,
  input  logic [7:0]    i_M_RX_Byte,
  output logic          o_SPI_CS_n
);

  // One shared timer serves the setup, hold and inactive phases. It must be
  // wide enough for the longest of the three intervals.
  localparam int TMAX_SH = (CS_SETUP_CLKS > CS_HOLD_CLKS) ? CS_SETUP_CLKS : CS_HOLD_CLKS;
  localparam int TMAX    = (TMAX_SH > CS_INACTIVE_CLKS) ? TMAX_SH : CS_INACTIVE_CLKS;
  localparam int TW      = (TMAX > 1) ? $clog2(TMAX) : 1;

  // Terminal timer values. A zero-length phase is bypassed entirely, so its
  // terminal value is never consulted and is held at zero.
  localparam logic [TW-1:0] SETUP_LAST = TW'((CS_SETUP_CLKS    > 0) ? CS_SETUP_CLKS    - 1 : 0);
  localparam logic [TW-1:0] HOLD_LAST  = TW'((CS_HOLD_CLKS     > 0) ? CS_HOLD_CLKS     - 1 : 0);
  localparam logic [TW-1:0] INACT_LAST = TW'((CS_INACTIVE_CLKS > 0) ? CS_INACTIVE_CLKS - 1 : 0);

  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_BYTES_PER_CS);
  localparam logic [CW-1:0] ONE_CNT = CW'(1'b1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_SETUP     = 3'd1,
    S_SEND      = 3'd2,
    S_WAIT_DONE = 3'd3,
    S_NEXT      = 3'd4,
    S_HOLD      = 3'd5,
    S_INACTIVE  = 3'd6
  } state_t;

  // Zero requests one byte; anything above the maximum is clamped to it.
  function automatic logic [CW-1:0] clamp_count(input logic [CW-1:0] cnt);
    logic [CW-1:0] res;
    if (cnt == '0) begin
      res = ONE_CNT;
    end else if (cnt > MAX_CNT) begin
      res = MAX_CNT;
    end else begin
      res = cnt;
    end
    return res;
  endfunction

  state_t        r_state;
  logic [TW-1:0] r_timer;
  logic [CW-1:0] r_remaining;
  logic          r_rx_seen;
  logic          r_tx_ready;
  logic          r_cs_n;
  logic [7:0]    r_m_tx_byte;
  logic          r_m_tx_dv;
  logic [CW-1:0] r_rx_count;
  logic          r_rx_dv;
  logic [7:0]    r_rx_byte;

  logic w_accept;
  logic w_byte_done;

  // A host byte is only taken while the sequencer advertises readiness, so
  // stray valids in any busy state fall through untouched.
  assign w_accept    = i_TX_DV & r_tx_ready;
  // Ready alone is not trusted: the master may still show ready the cycle
  // after our valid pulse, so completion also needs the received-byte flag.
  assign w_byte_done = r_rx_seen & i_M_TX_Ready;

  // Transaction FSM: chip select, phase timing, byte hand-off and RX index.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_state     <= S_IDLE;
      r_timer     <= '0;
      r_remaining <= '0;
      r_rx_seen   <= 1'b0;
      r_tx_ready  <= 1'b0;
      r_cs_n      <= 1'b1;
      r_m_tx_byte <= 8'h00;
      r_m_tx_dv   <= 1'b0;
      r_rx_count  <= '0;
    end else begin
      // The master valid is a one-cycle strobe unless a state re-arms it.
      r_m_tx_dv <= 1'b0;

      // Index advances after each byte is handed back; a new transaction
      // restart below takes precedence.
      if (r_rx_dv) begin
        r_rx_count <= r_rx_count + ONE_CNT;
      end

      case (r_state)
        S_IDLE: begin
          r_tx_ready <= i_M_TX_Ready;
          r_rx_seen  <= 1'b0;
          if (w_accept) begin
            r_m_tx_byte <= i_TX_Byte;
            r_remaining <= clamp_count(i_TX_Count);
            r_tx_ready  <= 1'b0;
            r_cs_n      <= 1'b0;
            r_rx_count  <= '0;
            r_timer     <= '0;
            if (CS_SETUP_CLKS == 0) begin
              r_m_tx_dv <= 1'b1;
              r_state   <= S_SEND;
            end else begin
              r_state <= S_SETUP;
            end
          end
        end

        S_SETUP: begin
          if (r_timer == SETUP_LAST) begin
            r_m_tx_dv <= 1'b1;
            r_state   <= S_SEND;
          end else begin
            r_timer <= r_timer + TW'(1'b1);
          end
        end

        S_SEND: begin
          if (i_M_RX_DV) begin
            r_rx_seen <= 1'b1;
          end
          r_state <= S_WAIT_DONE;
        end

        S_WAIT_DONE: begin
          if (w_byte_done) begin
            r_remaining <= r_remaining - ONE_CNT;
            r_rx_seen   <= 1'b0;
            r_timer     <= '0;
            if (r_remaining > ONE_CNT) begin
              r_tx_ready <= 1'b1;
              r_state    <= S_NEXT;
            end else if (CS_HOLD_CLKS == 0) begin
              r_cs_n  <= 1'b1;
              r_state <= (CS_INACTIVE_CLKS == 0) ? S_IDLE : S_INACTIVE;
            end else begin
              r_state <= S_HOLD;
            end
          end else if (i_M_RX_DV) begin
            r_rx_seen <= 1'b1;
          end
        end

        S_NEXT: begin
          // No setup delay between bytes of the same transaction.
          if (w_accept) begin
            r_m_tx_byte <= i_TX_Byte;
            r_m_tx_dv   <= 1'b1;
            r_tx_ready  <= 1'b0;
            r_state     <= S_SEND;
          end
        end

        S_HOLD: begin
          if (r_timer == HOLD_LAST) begin
            r_cs_n  <= 1'b1;
            r_timer <= '0;
            r_state <= (CS_INACTIVE_CLKS == 0) ? S_IDLE : S_INACTIVE;
          end else begin
            r_timer <= r_timer + TW'(1'b1);
          end
        end

        S_INACTIVE: begin
          if (r_timer == INACT_LAST) begin
            r_tx_ready <= i_M_TX_Ready;
            r_state    <= S_IDLE;
          end else begin
            r_timer <= r_timer + TW'(1'b1);
          end
        end

        default: begin
          r_state    <= S_IDLE;
          r_cs_n     <= 1'b1;
          r_tx_ready <= 1'b0;
          r_rx_seen  <= 1'b0;
          r_timer    <= '0;
        end
      endcase
    end
  end

  // Received bytes are forwarded with one cycle of latency in every state.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_rx_dv   <= 1'b0;
      r_rx_byte <= 8'h00;
    end else begin
      r_rx_dv <= i_M_RX_DV;
      if (i_M_RX_DV) begin
        r_rx_byte <= i_M_RX_Byte;
      end
    end
  end

  assign o_TX_Ready  = r_tx_ready;
  assign o_RX_Count  = r_rx_count;
  assign o_RX_DV     = r_rx_dv;
  assign o_RX_Byte   = r_rx_byte;
  assign o_M_TX_Byte = r_m_tx_byte;
  assign o_M_TX_DV   = r_m_tx_dv;
  assign o_SPI_CS_n  = r_cs_n;

endmodule

// File: tb/tb_spi_cs_sequencer.sv
// Directed bench for spi_cs_sequencer with default parameters (MAX=2, setup 4,
// hold 4, inactive 8). The SPI byte master is emulated inline with MISO
// looped back, so every received byte equals the byte just sent.
module tb_spi_cs_sequencer;
  localparam int CW = 2;

  logic          i_Clk = 1'b0;
  logic          i_Rst_L = 1'b1;
  logic [CW-1:0] i_TX_Count = '0;
  logic [7:0]    i_TX_Byte = 8'h00;
  logic          i_TX_DV = 1'b0;
  logic          o_TX_Ready;
  logic [CW-1:0] o_RX_Count;
  logic          o_RX_DV;
  logic [7:0]    o_RX_Byte;
  logic [7:0]    o_M_TX_Byte;
  logic          o_M_TX_DV;
  logic          i_M_TX_Ready = 1'b1;
  logic          i_M_RX_DV = 1'b0;
  logic [7:0]    i_M_RX_Byte = 8'h00;
  logic          o_SPI_CS_n;

  int checks = 0;
  int failures = 0;
  int dv_pulses = 0;
  int dv_cs_viol = 0;
  int cs_falls = 0;

  spi_cs_sequencer dut (
    .i_Clk(i_Clk), .i_Rst_L(i_Rst_L),
    .i_TX_Count(i_TX_Count), .i_TX_Byte(i_TX_Byte), .i_TX_DV(i_TX_DV),
    .o_TX_Ready(o_TX_Ready), .o_RX_Count(o_RX_Count), .o_RX_DV(o_RX_DV),
    .o_RX_Byte(o_RX_Byte), .o_M_TX_Byte(o_M_TX_Byte), .o_M_TX_DV(o_M_TX_DV),
    .i_M_TX_Ready(i_M_TX_Ready), .i_M_RX_DV(i_M_RX_DV), .i_M_RX_Byte(i_M_RX_Byte),
    .o_SPI_CS_n(o_SPI_CS_n)
  );

  always #5 i_Clk = ~i_Clk;

  // Background counters of master valid pulses and chip-select falls.
  always @(posedge i_Clk) begin
    if (o_M_TX_DV) dv_pulses++;
    if (o_M_TX_DV && o_SPI_CS_n) dv_cs_viol++;
  end

  always @(negedge o_SPI_CS_n) cs_falls++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_Clk);
    #1;
  endtask

  // Host launches a transaction from IDLE.
  task automatic start_txn(input logic [CW-1:0] cnt, input logic [7:0] b);
    chk("ready_before_start", o_TX_Ready, 1);
    i_TX_Count = cnt;
    i_TX_Byte  = b;
    i_TX_DV    = 1'b1;
    tick();
    i_TX_DV    = 1'b0;
    chk("cs_falls_on_start", o_SPI_CS_n, 0);
    chk("ready_drops_on_start", o_TX_Ready, 0);
    chk("rx_count_cleared", o_RX_Count, 0);
  endtask

  task automatic wait_dv(output int n);
    n = 0;
    while (!o_M_TX_DV && n < 50) begin
      tick();
      n++;
    end
  endtask

  // Called right after o_M_TX_DV is seen high; plays the master and ends on
  // the clock edge at which the byte completes.
  task automatic finish_byte(input logic [7:0] exp_tx, input int idx, input bit stray);
    chk("m_tx_byte", o_M_TX_Byte, exp_tx);
    chk("cs_low_at_dv", o_SPI_CS_n, 0);
    tick();
    chk("dv_single_cycle", o_M_TX_DV, 0);
    tick();                      // master ready still high into WAIT_DONE
    i_M_TX_Ready = 1'b0;
    if (stray) begin
      i_TX_DV   = 1'b1;
      i_TX_Byte = 8'hFF;
      i_TX_Count = 2'd2;
    end
    tick();
    i_TX_DV = 1'b0;
    repeat (3) tick();
    i_M_RX_DV   = 1'b1;
    i_M_RX_Byte = exp_tx;
    tick();
    chk("rx_dv", o_RX_DV, 1);
    chk("rx_byte", o_RX_Byte, exp_tx);
    chk("rx_index", o_RX_Count, idx);
    i_M_RX_DV    = 1'b0;
    i_M_RX_Byte  = 8'h00;
    i_M_TX_Ready = 1'b1;
    tick();
    chk("rx_dv_pulse", o_RX_DV, 0);
    chk("rx_index_incr", o_RX_Count, idx + 1);
  endtask

  // From the byte-done edge: CS rises after hold, ready returns after inactive.
  task automatic finish_txn(input bit stray);
    int n;
    n = 0;
    while (!o_SPI_CS_n && n < 50) begin
      tick();
      n++;
    end
    chk("hold_clks", n, 4);
    n = 0;
    i_TX_DV = stray;
    while (!o_TX_Ready && n < 50) begin
      tick();
      i_TX_DV = 1'b0;
      n++;
    end
    chk("inactive_clks", n, 8);
    chk("cs_high_idle", o_SPI_CS_n, 1);
  endtask

  initial begin
    int n;
    int d0;
    int f0;
    int cs_hi;

    // Reset
    #2 i_Rst_L = 1'b0;
    #1;
    chk("rst_cs_n", o_SPI_CS_n, 1);
    chk("rst_tx_ready", o_TX_Ready, 0);
    chk("rst_m_tx_dv", o_M_TX_DV, 0);
    chk("rst_m_tx_byte", o_M_TX_Byte, 0);
    chk("rst_rx_dv", o_RX_DV, 0);
    chk("rst_rx_byte", o_RX_Byte, 0);
    chk("rst_rx_count", o_RX_Count, 0);
    tick();
    i_Rst_L = 1'b1;
    tick();
    chk("ready_after_rst", o_TX_Ready, 1);

    // Single byte 0xC1
    d0 = dv_pulses; f0 = cs_falls;
    start_txn(2'd1, 8'hC1);
    wait_dv(n);
    chk("setup_clks", n, 4);
    finish_byte(8'hC1, 0, 1'b0);
    finish_txn(1'b0);
    chk("single_dv_pulses", dv_pulses - d0, 1);
    chk("single_cs_falls", cs_falls - f0, 1);

    // Two bytes 0xBE, 0xEF under one CS
    d0 = dv_pulses; f0 = cs_falls;
    start_txn(2'd2, 8'hBE);
    wait_dv(n);
    chk("setup_clks_2b", n, 4);
    finish_byte(8'hBE, 0, 1'b0);
    chk("next_ready", o_TX_Ready, 1);
    chk("next_cs_low", o_SPI_CS_n, 0);
    i_TX_Byte = 8'hEF; i_TX_DV = 1'b1;
    tick();
    i_TX_DV = 1'b0;
    chk("next_dv_immediate", o_M_TX_DV, 1);
    chk("next_ready_drop", o_TX_Ready, 0);
    finish_byte(8'hEF, 1, 1'b0);
    finish_txn(1'b0);
    chk("two_dv_pulses", dv_pulses - d0, 2);
    chk("two_cs_falls", cs_falls - f0, 1);

    // Count 0 behaves as one byte
    d0 = dv_pulses;
    start_txn(2'd0, 8'h3C);
    wait_dv(n);
    finish_byte(8'h3C, 0, 1'b0);
    chk("cnt0_no_next", o_TX_Ready, 0);
    finish_txn(1'b0);
    chk("cnt0_dv_pulses", dv_pulses - d0, 1);

    // Count 3 clamps to 2
    d0 = dv_pulses;
    start_txn(2'd3, 8'h11);
    wait_dv(n);
    finish_byte(8'h11, 0, 1'b0);
    i_TX_Byte = 8'h22; i_TX_DV = 1'b1;
    tick();
    i_TX_DV = 1'b0;
    finish_byte(8'h22, 1, 1'b0);
    chk("clamp_no_next", o_TX_Ready, 0);
    finish_txn(1'b0);
    chk("clamp_dv_pulses", dv_pulses - d0, 2);

    // Host stalls 200 clocks in NEXT
    d0 = dv_pulses;
    start_txn(2'd2, 8'h12);
    wait_dv(n);
    finish_byte(8'h12, 0, 1'b0);
    cs_hi = 0;
    repeat (200) begin
      tick();
      if (o_SPI_CS_n) cs_hi++;
    end
    chk("stall_cs_low", cs_hi, 0);
    chk("stall_no_dv", dv_pulses - d0, 1);
    chk("stall_ready", o_TX_Ready, 1);
    i_TX_Byte = 8'h34; i_TX_DV = 1'b1;
    tick();
    i_TX_DV = 1'b0;
    chk("stall_resume_dv", o_M_TX_DV, 1);
    finish_byte(8'h34, 1, 1'b0);
    finish_txn(1'b0);

    // Stray valids in SETUP, WAIT_DONE and INACTIVE
    d0 = dv_pulses;
    start_txn(2'd1, 8'h5A);
    i_TX_DV = 1'b1; i_TX_Byte = 8'hFF; i_TX_Count = 2'd2;
    tick();
    i_TX_DV = 1'b0;
    wait_dv(n);
    chk("stray_setup_clks", n, 3);
    finish_byte(8'h5A, 0, 1'b1);
    chk("stray_no_next", o_TX_Ready, 0);
    finish_txn(1'b1);
    chk("stray_dv_pulses", dv_pulses - d0, 1);

    // Reset during WAIT_DONE of a two-byte transaction
    start_txn(2'd2, 8'h77);
    wait_dv(n);
    tick();
    tick();
    i_M_TX_Ready = 1'b0;
    #2 i_Rst_L = 1'b0;
    #1;
    chk("midrst_cs_n", o_SPI_CS_n, 1);
    chk("midrst_tx_ready", o_TX_Ready, 0);
    chk("midrst_m_tx_dv", o_M_TX_DV, 0);
    chk("midrst_m_tx_byte", o_M_TX_Byte, 0);
    chk("midrst_rx_dv", o_RX_DV, 0);
    chk("midrst_rx_byte", o_RX_Byte, 0);
    chk("midrst_rx_count", o_RX_Count, 0);
    i_M_TX_Ready = 1'b1;
    tick();
    tick();
    i_Rst_L = 1'b1;
    tick();
    d0 = dv_pulses; f0 = cs_falls;
    start_txn(2'd1, 8'hA5);
    wait_dv(n);
    chk("post_rst_setup", n, 4);
    finish_byte(8'hA5, 0, 1'b0);
    finish_txn(1'b0);
    chk("post_rst_dv_pulses", dv_pulses - d0, 1);
    chk("post_rst_cs_falls", cs_falls - f0, 1);

    chk("dv_while_cs_high", dv_cs_viol, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/spi_cs_sequencer.md
Name: spi_cs_sequencer

Overview:
Transaction sequencer that sits directly upstream of SPI_Master and drives its byte interface (i_TX_Byte/i_TX_DV/o_TX_Ready, o_RX_DV/o_RX_Byte).
Groups N consecutive bytes under one active-low chip select. Enforces CS setup, hold and inactive times in system clocks.
Forwards received bytes to the host, tagged with their index within the transaction.

Parameters:
MAX_BYTES_PER_CS, 2, maximum bytes per CS assertion; count width CW = $clog2(MAX_BYTES_PER_CS+1)
CS_SETUP_CLKS, 4, i_Clk cycles from CS_n falling to first o_M_TX_DV pulse
CS_HOLD_CLKS, 4, i_Clk cycles from last byte done to CS_n rising
CS_INACTIVE_CLKS, 8, minimum i_Clk cycles CS_n stays high before the next transaction

Ports:
i_Clk  in  1  system clock, all logic on rising edge
i_Rst_L  in  1  asynchronous active-low reset
i_TX_Count  in  CW  bytes in transaction, sampled only with the first i_TX_DV of a transaction
i_TX_Byte  in  8  host byte to send
i_TX_DV  in  1  host byte valid, single-cycle pulse
o_TX_Ready  out  1  sequencer can accept a byte
o_RX_Count  out  CW  index (0-based) of the byte on o_RX_Byte
o_RX_DV  out  1  received byte valid, single-cycle pulse
o_RX_Byte  out  8  received byte
o_M_TX_Byte  out  8  to SPI_Master i_TX_Byte
o_M_TX_DV  out  1  to SPI_Master i_TX_DV
i_M_TX_Ready  in  1  from SPI_Master o_TX_Ready
i_M_RX_DV  in  1  from SPI_Master o_RX_DV
i_M_RX_Byte  in  8  from SPI_Master o_RX_Byte
o_SPI_CS_n  out  1  chip select, active low

Behaviour:
- Reset (async, i_Rst_L=0): o_SPI_CS_n=1, o_TX_Ready=0, o_M_TX_DV=0, o_M_TX_Byte=0, o_RX_DV=0, o_RX_Byte=0, o_RX_Count=0; state IDLE. CS_n must rise immediately on reset, even mid-transaction.
- States: IDLE, SETUP, SEND, WAIT_DONE, NEXT, HOLD, INACTIVE.
- IDLE: o_TX_Ready = i_M_TX_Ready (registered). i_TX_DV with o_TX_Ready=1 does all of the following:
  - latches byte and count; count 0 is treated as 1, count > MAX_BYTES_PER_CS is clamped to MAX;
  - next cycle: o_TX_Ready=0, CS_n=0, o_RX_Count=0, go to SETUP.
- SETUP: CS_n held low CS_SETUP_CLKS cycles, then SEND. CS_SETUP_CLKS=0 goes straight to SEND.
- SEND: o_M_TX_DV=1 for exactly one cycle with latched byte on o_M_TX_Byte, then WAIT_DONE.
- WAIT_DONE: a sticky flag sets on i_M_RX_DV. Byte done = flag set AND i_M_TX_Ready=1. Do not test i_M_TX_Ready alone; it may still be high the cycle after the DV pulse.
  - On byte done: remaining decrements and the flag clears.
  - remaining>0: go to NEXT.
  - remaining==0: go to HOLD.
- NEXT: o_TX_Ready=1, CS_n stays low, waits indefinitely. On i_TX_DV, latch the byte, set o_TX_Ready=0, go to SEND (no setup delay between bytes).
- HOLD: CS_HOLD_CLKS cycles with CS_n low, then CS_n=1, go to INACTIVE.
- INACTIVE: CS_INACTIVE_CLKS cycles with CS_n high, then IDLE.
- RX path, any state: i_M_RX_DV is registered to o_RX_DV/o_RX_Byte with 1-cycle latency. o_RX_Count shows the current byte index, then increments after each o_RX_DV.
- i_TX_DV while o_TX_Ready=0 is ignored: no latch, no error.
- i_TX_Count is ignored outside IDLE.
- o_M_TX_DV is never asserted while CS_n=1.
- o_M_TX_DV is never asserted twice without an intervening byte done.

Test Plan:
- Single byte, count=1, 0xC1, MISO looped to MOSI → CS_n falls, o_M_TX_DV exactly 4 clks later, o_RX_DV with 0xC1 and o_RX_Count=0, CS_n rises 4 clks after byte done, o_TX_Ready returns ≥8 clks after CS_n rises.
- Two-byte transaction, count=2, bytes 0xBE then 0xEF (host waits for o_TX_Ready) → CS_n low continuously across both bytes; RX 0xBE idx 0, 0xEF idx 1; one CS_n low pulse only.
- Clamp cases: count=0 → behaves as 1 byte; count=3 with MAX=2 → CS_n rises after the second byte.
- Host stall in NEXT for 200 clks → CS_n stays low, no o_M_TX_DV until the host pulses i_TX_DV, then normal completion.
- Stray i_TX_DV during SETUP, WAIT_DONE and INACTIVE → ignored, no extra o_M_TX_DV, byte count unchanged.
- Assert i_Rst_L=0 mid-WAIT_DONE of a 2-byte transaction → CS_n=1 and all outputs at reset values asynchronously. After release, a new count=1 0xA5 transaction completes correctly.
